// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/operand/result bundle between an ALU pipeline and the serial subtractor
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   modport master (
      output start, a, b,
      input  busy, done, diff, flag_n, flag_z, flag_c, flag_v
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, flag_n, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first, one bit per clock, with NZCV flags (C = ~borrow)
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_subtractor_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             borrow_q, borrow_d;
   logic             a_msb_q,  a_msb_d;
   logic             b_msb_q,  b_msb_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic             bit_d;
   logic             last_bit;

   assign bit_d    = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
   assign last_bit = (count_q == CW'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      count_d  = count_q;
      borrow_d = borrow_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      busy_d   = busy_q;
      done_d   = done_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d  = RUN;
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               a_msb_d  = bus.a[WIDTH-1];
               b_msb_d  = bus.b[WIDTH-1];
               diff_d   = '0;
               count_d  = '0;
               borrow_d = 1'b0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
            end
         end
         RUN: begin
            // start is deliberately not looked at here: operands stay as latched
            diff_d   = {bit_d, diff_q[WIDTH-1:1]};
            borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            if (last_bit) begin
               // counter parks at WIDTH-1 so it never wraps
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         count_q  <= '0;
         borrow_q <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         diff_q   <= diff_d;
         count_q  <= count_d;
         borrow_q <= borrow_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // flags are only meaningful once the last bit is in
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.flag_n = done_q & diff_q[WIDTH-1];
   assign bus.flag_z = done_q & (diff_q == '0);
   assign bus.flag_c = done_q & ~borrow_q;
   assign bus.flag_v = done_q & (a_msb_q != b_msb_q) & (diff_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed-vector bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   lat;
   int   cyc;
   int   last_done;
   int   n_done;

   serial_subtractor_if #(.WIDTH(8)) bus_if ();

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {bus_if.flag_n, bus_if.flag_z, bus_if.flag_c, bus_if.flag_v};
   endfunction

   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] exp_d, input logic [3:0] exp_f, input string tag);
      int l;
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.a     = av;
      bus_if.b     = bv;
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.a     = ~av;
      bus_if.b     = av ^ bv ^ 8'h5A;
      l = 0;
      while (!bus_if.done && l < 20) begin
         @(negedge clk);
         l++;
      end
      chk({tag, "_latency"}, l, 8);
      chk({tag, "_diff"}, bus_if.diff, exp_d);
      chk({tag, "_nzcv"}, flags(), exp_f);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n        = 1'b0;
      bus_if.start = 1'b0;
      bus_if.a     = '0;
      bus_if.b     = '0;
      #2;
      chk("reset_busy", bus_if.busy, 0);
      chk("reset_done", bus_if.done, 0);
      chk("reset_diff", bus_if.diff, 0);
      chk("reset_nzcv", flags(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_done", bus_if.done, 0);

      run_op(8'h05, 8'h03, 8'h02, 4'b0010, "5m3");
      repeat (3) @(negedge clk);
      chk("hold_done", bus_if.done, 1);
      chk("hold_diff", bus_if.diff, 8'h02);
      chk("hold_nzcv", flags(), 4'b0010);

      run_op(8'h03, 8'h05, 8'hFE, 4'b1000, "3m5");
      run_op(8'h80, 8'h01, 8'h7F, 4'b0011, "80m01");
      run_op(8'h7F, 8'hFF, 8'h80, 4'b1001, "7Fm FF");
      run_op(8'h2A, 8'h2A, 8'h00, 4'b0110, "2Am2A");

      // start pulsed with new operands during RUN must be ignored
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.a     = 8'h64;
      bus_if.b     = 8'h14;
      @(posedge clk);
      @(negedge clk);
      chk("run_busy", bus_if.busy, 1);
      chk("run_done_low", bus_if.done, 0);
      lat = 0;
      while (!bus_if.done && lat < 20) begin
         bus_if.start = (lat == 2);
         if (lat == 2) begin
            bus_if.a = 8'hFF;
            bus_if.b = 8'h01;
         end
         @(negedge clk);
         lat++;
      end
      bus_if.start = 1'b0;
      chk("hz_start_latency", lat, 8);
      chk("hz_start_diff", bus_if.diff, 8'h50);
      chk("hz_start_nzcv", flags(), 4'b0010);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.a     = 8'h0F;
      bus_if.b     = 8'h00;
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", bus_if.busy, 0);
      chk("arst_done", bus_if.done, 0);
      chk("arst_diff", bus_if.diff, 0);
      chk("arst_nzcv", flags(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h10, 8'h20, 8'hF0, 4'b1000, "post_rst");

      // start held high: back-to-back operations, fresh operands each completion
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.a     = 8'h09;
      bus_if.b     = 8'h04;
      @(posedge clk);
      cyc       = 0;
      last_done = 0;
      n_done    = 0;
      while (n_done < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus_if.done) begin
            n_done++;
            if (n_done == 1) begin
               chk("b2b_first_latency", cyc, 9);
               chk("b2b_diff1", bus_if.diff, 8'h05);
               bus_if.a = 8'h20;
               bus_if.b = 8'h30;
            end else if (n_done == 2) begin
               chk("b2b_period2", cyc - last_done, 9);
               chk("b2b_diff2", bus_if.diff, 8'hF0);
               chk("b2b_nzcv2", flags(), 4'b1000);
               bus_if.a = 8'h01;
               bus_if.b = 8'h01;
            end else begin
               chk("b2b_period3", cyc - last_done, 9);
               chk("b2b_diff3", bus_if.diff, 8'h00);
               chk("b2b_nzcv3", flags(), 4'b0110);
            end
            last_done = cyc;
         end
      end
      chk("b2b_count", n_done, 3);
      bus_if.start = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
